// File: rtl/cpu_pkg.sv
// Shared front-end definitions: prefetch FSM encoding, NOP word, reset PC and
// the buffered fetch entry layout.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_4;
    } fetch_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {instr, pc+4}; flush beats push, and a push
// into a full FIFO is only accepted alongside a pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output fetch_entry_t           head_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: single-outstanding fetch over req/ack into a small
// FIFO feeding IF/ID, with flush and refetch on a taken-branch redirect.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no request outstanding; issue one when the FIFO has room
//   ST_WAIT | request to mem_addr_o outstanding; ack data gets buffered
//   ST_DROP | request outstanding but redirected; ack data is discarded
module instr_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_4_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occ_after;
    logic             full, empty;
    logic             pop, push, flush;
    fetch_entry_t     head, push_entry;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .count_o     (count),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign valid_o    = !empty;
    assign pop        = valid_o && !stall_i && !redirect_i;
    assign instr_o    = valid_o ? head.instr : NOP_INSTR;
    assign pc_4_o     = valid_o ? head.pc_4 : 32'h0;
    assign mem_req_o  = (state_q != ST_IDLE);
    assign mem_addr_o = addr_q;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        addr_d           = addr_q;
        push             = 1'b0;
        flush            = 1'b0;
        push_entry.instr = mem_data_i;
        push_entry.pc_4  = pc_inc(addr_q);
        occ_after        = count + CNT_W'(1) - CNT_W'(pop);

        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_i;
                end else if (!full || pop) begin
                    state_d = ST_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_i;
                    state_d    = mem_ack_i ? ST_IDLE : ST_DROP;
                end else if (mem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_inc(addr_q);
                    // Keep the request line up for back-to-back fetch while room remains.
                    if (occ_after < CNT_W'(DEPTH)) begin
                        addr_d = pc_inc(addr_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // FIFO is already empty here; a new target only retargets fetch_pc.
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: latency-programmable memory
// model plus a queue-based reference of the expected instruction stream.
module tb_instr_prefetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_4_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;

    always #5 clk_i = ~clk_i;

    instr_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_4_o        (pc_4_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int mem_lat  = 1;
    bit rand_lat = 1'b0;
    int mem_cnt  = 0;

    // reference: buffered {instr, pc+4}, next fetch address, outstanding request
    logic [63:0] mq[$];
    logic [31:0] m_fpc  = RPC;
    logic [31:0] m_addr = RPC;
    bit          m_act  = 1'b0;
    bit          m_drop = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    function automatic logic [97:0] exp_vec();
        logic [63:0] h;
        logic        v;
        v = (mq.size() != 0);
        h = 64'h0;
        if (v) h = mq[0];
        return {v, h, m_act, (m_act ? m_addr : 32'h0)};
    endfunction

    function automatic logic [97:0] act_vec();
        return {valid_o, instr_o, pc_4_o, mem_req_o, (mem_req_o ? mem_addr_o : 32'h0)};
    endfunction

    function automatic void model_edge();
        bit pop;
        if (!rst_i) begin
            mq.delete();
            m_fpc  = RPC;
            m_addr = RPC;
            m_act  = 1'b0;
            m_drop = 1'b0;
            return;
        end
        pop = (mq.size() != 0) && !stall_i && !redirect_i;
        if (redirect_i) begin
            if (!(m_act && m_drop)) mq.delete();
            m_fpc = redirect_pc_i;
        end
        if (m_act) begin
            if (mem_ack_i) begin
                if (m_drop || redirect_i) begin
                    m_act = 1'b0;
                end else begin
                    mq.push_back({mem_data_i, m_addr + 32'd4});
                    m_fpc = m_addr + 32'd4;
                    if (pop) void'(mq.pop_front());
                    if (mq.size() < DEPTH) m_addr = m_addr + 32'd4;
                    else m_act = 1'b0;
                end
            end else begin
                if (redirect_i) m_drop = 1'b1;
                if (pop) void'(mq.pop_front());
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (!redirect_i && mq.size() < DEPTH) begin
                m_act  = 1'b1;
                m_drop = 1'b0;
                m_addr = m_fpc;
            end
        end
    endfunction

    // Called at a negedge: apply inputs (memory answers from its own counter),
    // take one rising edge, advance the reference, return at the next negedge.
    task automatic step(input bit rst_v, input bit redir_v, input logic [31:0] rpc_v,
                        input bit stall_v);
        rst_i         = rst_v;
        redirect_i    = redir_v;
        redirect_pc_i = rpc_v;
        stall_i       = stall_v;
        mem_ack_i     = 1'b0;
        mem_data_i    = $urandom;
        if (!rst_v) begin
            mem_cnt = 0;
        end else if (mem_req_o) begin
            if (mem_cnt == 0 && rand_lat) mem_lat = $urandom_range(1, 4);
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_word(mem_addr_o);
                mem_cnt    = 0;
            end
        end
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        mem_lat  = 1;
        rand_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++;
            if ({valid_o, instr_o, pc_4_o, mem_req_o, mem_addr_o} !== {1'b0, 32'h0, 32'h0, 1'b0, RPC}) begin
                failures++;
                $display("FAIL reset_values cyc=%0d got v=%0b i=%h p=%h r=%0b a=%h want all zero/RESET_PC",
                         cyc, valid_o, instr_o, pc_4_o, mem_req_o, mem_addr_o);
            end
        end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, RPC}) begin
            failures++;
            $display("FAIL first_request got req=%0b addr=%h want req=1 addr=%h",
                     mem_req_o, mem_addr_o, RPC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc4;
        mem_lat = 1;
        do_reset();
        exp_pc4 = 32'd4;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stream_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (valid_o) begin
                checks++;
                if ({pc_4_o, instr_o} !== {exp_pc4, mem_word(exp_pc4 - 32'd4)}) begin
                    failures++;
                    $display("FAIL stream_order cyc=%0d got pc4=%h instr=%h want pc4=%h instr=%h",
                             cyc, pc_4_o, instr_o, exp_pc4, mem_word(exp_pc4 - 32'd4));
                end
                exp_pc4 = exp_pc4 + 32'd4;
            end
        end
    endtask

    task automatic test_stall_full();
        int  acks;
        bit  seen;
        mem_lat = 1;
        do_reset();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (mem_ack_i) acks++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stall_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (acks != DEPTH || {mem_req_o, valid_o, pc_4_o, instr_o} !== {1'b0, 1'b1, 32'd4, mem_word(32'h0)}) begin
            failures++;
            $display("FAIL stall_full got acks=%0d req=%0b v=%0b pc4=%h want acks=%0d req=0 v=1 pc4=4",
                     acks, mem_req_o, valid_o, pc_4_o, DEPTH);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (mem_req_o && !seen) begin
                seen = 1'b1;
                checks++;
                if (mem_addr_o !== 32'd16) begin
                    failures++;
                    $display("FAIL resume_addr got=%h want=%h", mem_addr_o, 32'd16);
                end
            end
        end
    endtask

    task automatic test_redirect_buffered();
        bit seen;
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 10 && mq.size() != 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (!valid_o || mq.size() != 3) begin
            failures++;
            $display("FAIL redir_setup got v=%0b ref_count=%0d want v=1 ref_count=3", valid_o, mq.size());
        end
        step(1'b1, 1'b1, 32'h100, 1'b1);
        checks++;
        if ({valid_o, instr_o, pc_4_o} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL redir_flush got v=%0b i=%h p=%h want v=0 i=0 p=0", valid_o, instr_o, pc_4_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (act_vec() !== exp_vec() || (valid_o && pc_4_o < 32'h104)) begin
                failures++;
                $display("FAIL redir_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (mem_req_o && !seen) begin
                seen = 1'b1;
                checks++;
                if (mem_addr_o !== 32'h100) begin
                    failures++;
                    $display("FAIL redir_addr got=%h want=%h", mem_addr_o, 32'h100);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL redir_timeout got no request want request to 00000100");
        end
    endtask

    task automatic test_drop();
        bit got;
        mem_lat = 3;
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        checks++;
        if ({mem_req_o, mem_addr_o, valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL drop_hold got req=%0b addr=%h v=%0b want req=1 addr=0 v=0",
                     mem_req_o, mem_addr_o, valid_o);
        end
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL drop_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (valid_o) begin
                got = 1'b1;
                checks++;
                if ({pc_4_o, instr_o} !== {32'h44, mem_word(32'h40)}) begin
                    failures++;
                    $display("FAIL drop_first got pc4=%h instr=%h want pc4=00000044 instr=%h",
                             pc_4_o, instr_o, mem_word(32'h40));
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL drop_timeout got valid=0 want valid within 16 cycles");
        end
    endtask

    task automatic test_redirect_ack_pop();
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({valid_o, mem_req_o} !== 2'b11) begin
            failures++;
            $display("FAIL rap_setup got v=%0b req=%0b want v=1 req=1", valid_o, mem_req_o);
        end
        step(1'b1, 1'b1, 32'h200, 1'b0);
        checks++;
        if ({mem_ack_i, valid_o, mem_req_o} !== 3'b100) begin
            failures++;
            $display("FAIL rap_flush got ack=%0b v=%0b req=%0b want ack=1 v=0 req=0",
                     mem_ack_i, valid_o, mem_req_o);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({mem_req_o, mem_addr_o, valid_o} !== {1'b1, 32'h200, 1'b0}) begin
            failures++;
            $display("FAIL rap_refetch got req=%0b addr=%h v=%0b want req=1 addr=00000200 v=0",
                     mem_req_o, mem_addr_o, valid_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rmw_setup got req=%0b want req=1", mem_req_o);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({valid_o, instr_o, pc_4_o, mem_req_o, mem_addr_o} !== {1'b0, 32'h0, 32'h0, 1'b0, RPC}) begin
            failures++;
            $display("FAIL rmw_reset got v=%0b i=%h p=%h r=%0b a=%h want all zero/RESET_PC",
                     valid_o, instr_o, pc_4_o, mem_req_o, mem_addr_o);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rmw_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit          r, s, rs;
        logic [31:0] t;
        rand_lat = 1'b1;
        mem_cnt  = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 199) != 0);
            r  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            step(rs, r, t, s);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        rand_lat = 1'b0;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect_buffered();
        test_drop();
        test_redirect_ack_pop();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction prefetch unit for the 5-stage pipelined CPU. It sits directly upstream of the IF/ID pipeline register and replaces the direct PC → instruction-memory path. It fetches instructions from a multi-cycle instruction memory over a request/acknowledge handshake and buffers up to DEPTH fetched instructions, each with its PC+4. It also discards in-flight and buffered instructions when a taken branch in MEM redirects the PC.

## Interface
- DEPTH, 4, number of buffered instructions; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-low
- redirect_i  in  1  taken branch from MEM stage; flush and refetch
- redirect_pc_i  in  32  branch target, sampled when redirect_i=1
- stall_i  in  1  IF/ID cannot accept this cycle
- valid_o  out  1  instr_o/pc_4_o hold a valid instruction
- instr_o  out  32  head instruction; 32'h0 (NOP) when valid_o=0
- pc_4_o  out  32  PC+4 of head instruction; 0 when valid_o=0
- mem_req_o  out  1  fetch request, held until acknowledged
- mem_addr_o  out  32  fetch address, stable while mem_req_o=1
- mem_ack_i  in  1  memory completes request this cycle
- mem_data_i  in  32  instruction word, valid when mem_ack_i=1

## Operation
- Registers:
  - fetch_pc: next address to request.
  - count: occupancy, 0..DEPTH.
  - State: IDLE, WAIT or DROP.
  - FIFO storage of {instr, pc+4}.
- At most one outstanding request.
- Pop: valid_o && !stall_i && !redirect_i. The head advances on the next edge.
- IDLE:
  - If count_next < DEPTH and !redirect_i: go to WAIT, mem_req_o=1, mem_addr_o=fetch_pc.
  - Otherwise stay in IDLE.
- WAIT with mem_ack_i=1 and !redirect_i:
  - Push {mem_data_i, mem_addr_o+4}.
  - fetch_pc = mem_addr_o+4.
  - If count+1−pop < DEPTH: stay in WAIT with mem_addr_o = mem_addr_o+4 (back-to-back fetch).
  - Otherwise go to IDLE with mem_req_o=0.
- WAIT with redirect_i=1:
  - Flush: count=0.
  - fetch_pc = redirect_pc_i.
  - If mem_ack_i=1 the same cycle: discard the data and go to IDLE.
  - Otherwise go to DROP, keeping mem_req_o and mem_addr_o unchanged.
- DROP:
  - Wait for mem_ack_i, discard mem_data_i, then go to IDLE.
  - A further redirect in DROP only updates fetch_pc.
- IDLE with redirect_i=1: flush, fetch_pc = redirect_pc_i, stay in IDLE for that cycle.
- Priority: redirect > ack push > pop. Push and pop in the same cycle leave count unchanged.
- mem_ack_i while in IDLE is ignored.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. No alignment checks.

## Timing
- Reset values (rst_i=0 at an edge):
  - count=0, state IDLE, fetch_pc=RESET_PC.
  - valid_o=0, instr_o=0, pc_4_o=0.
  - mem_req_o=0, mem_addr_o=RESET_PC.
- First request: mem_req_o=1 the first cycle after rst_i returns high.
- Reset mid-request abandons the request. The memory shares rst_i.
- Latency: an ack at edge N gives valid_o=1 with that instruction in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle with a 1-cycle-ack memory.
- Outputs are combinational reads of the registered FIFO head and count. There is no combinational path from mem_data_i to instr_o.
- Redirect at edge N:
  - valid_o=0 in cycle N+1.
  - The first request to redirect_pc_i is issued in cycle N+2 from IDLE, or later if DROP was entered.
- Full FIFO: no request is issued. A pop at edge N allows a request from cycle N+1.
- Empty FIFO with stall_i=1: no effect.

## Structure
- Shared package cpu_pkg holds:
  - The state encoding (IDLE, WAIT, DROP).
  - NOP_INSTR = 32'h0.
  - The RESET_PC default.
- Sub-module fetch_fifo holds the storage:
  - DEPTH-entry, 64-bit wide, synchronous.
  - push, pop and flush inputs; count, head data and full/empty outputs.
  - Flush has priority over push.

## Test plan
- Reset, 1-cycle-ack memory, stall_i=0 → requests to 0,4,8,… on consecutive cycles; instr_o follows the memory contents; pc_4_o = 4,8,12.
- stall_i=1 held, 1-cycle ack → exactly 4 pushes, mem_req_o drops, valid_o stays 1 with the head from addr 0. Release stall → one pop per cycle and fetch resumes at 16.
- Redirect to 32'h100 while 3 instructions are buffered → valid_o=0 next cycle; the next request goes to 32'h100; no stale instruction ever appears.
- 3-cycle ack memory, redirect to 32'h40 in the first wait cycle → DROP; the data acked for the old address is discarded; the next request goes to 32'h40.
- Redirect coincident with mem_ack_i and a pop → data discarded, count=0, state IDLE.
- rst_i=0 asserted in the middle of a WAIT → all outputs at reset values on the next cycle; refetch starts from RESET_PC.
